// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder slice.
//   mem_state_t : responder FSM states
//   word_t      : 32-bit memory word
//   MAX_WAIT    : largest supported wait-state count (sizes the wait counter)
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAITING, RESP} mem_state_t;

  typedef logic [31:0] word_t;

  localparam int MAX_WAIT = 15;

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 storage.
//   One synchronous write port, shared between the access path and the
//   preload path (the access path wins if both strobe), and one
//   combinational read port.
// Ports:
//   clk                          clock
//   acc_we, acc_idx, acc_data    committed access write
//   load_we, load_idx, load_data preload write (already qualified by caller)
//   raddr, rdata                 combinational read
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          acc_we,
  input  logic [AW-1:0] acc_idx,
  input  word_t         acc_data,
  input  logic          load_we,
  input  logic [AW-1:0] load_idx,
  input  word_t         load_data,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // NOTE: storage has no reset on purpose; contents must survive a reset
  // pulse, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      mem[acc_idx] <= acc_data;
    end else if (load_we) begin
      mem[load_idx] <= load_data;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: slave end of the multicycle core's memory interface.
//   Accepts one read/write at a time, answers with a one-cycle ready pulse
//   WAIT+1 cycles after the accept edge, flags misaligned/out-of-range
//   accesses on err, and counts committed writes.
// Ports:
//   clk, reset                       clock, async active-high reset
//   req, we, addr, wdata             request (captured at accept)
//   rdata, ready, err                registered response (one cycle)
//   wr_count                         committed-write counter, wraps
//   load_en, load_addr, load_data    preload port (IDLE with req=0 only)
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [15:0]              wr_count,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic          ZERO_WAIT = (WAIT == 0);
  localparam logic [CW-1:0] CNT_LOAD  = (WAIT > 0) ? CW'(WAIT - 1) : '0;

  mem_state_t    state, state_next;
  logic [CW-1:0] cnt;
  logic          cap_we, cap_bad;
  logic [AW-1:0] cap_idx;
  word_t         cap_wdata;

  logic          accept, in_bad, cnt_done, enter_resp;
  logic          resp_we, resp_bad;
  logic [AW-1:0] in_idx, resp_idx;
  word_t         resp_wdata, mem_rdata;
  logic          acc_we, load_we;

  assign accept   = req && (state == IDLE || state == RESP);
  assign in_bad   = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
  assign in_idx   = addr[AW+1:2];
  assign cnt_done = (state == WAITING) && (cnt == '0);

  // With zero wait states the accept edge is also the RESP-entry edge, so the
  // live request fields are used instead of the captured ones.
  assign enter_resp = cnt_done || (ZERO_WAIT && accept);
  assign resp_we    = cnt_done ? cap_we    : we;
  assign resp_bad   = cnt_done ? cap_bad   : in_bad;
  assign resp_idx   = cnt_done ? cap_idx   : in_idx;
  assign resp_wdata = cnt_done ? cap_wdata : wdata;

  // A write commits on the edge that enters RESP; bad accesses never commit.
  assign acc_we  = enter_resp && resp_we && !resp_bad;
  assign load_we = load_en && (state == IDLE) && !req;

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .acc_we    (acc_we),
    .acc_idx   (resp_idx),
    .acc_data  (resp_wdata),
    .load_we   (load_we),
    .load_idx  (load_addr),
    .load_data (load_data),
    .raddr     (resp_idx),
    .rdata     (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req) state_next = ZERO_WAIT ? RESP : WAITING;
      WAITING: if (cnt == '0) state_next = RESP;
      RESP:    if (req) state_next = ZERO_WAIT ? RESP : WAITING;
                else     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop sees
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_bad   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      wr_count  <= '0;
    end else begin
      if (accept) begin
        cap_we    <= we;
        cap_bad   <= in_bad;
        cap_idx   <= in_idx;
        cap_wdata <= wdata;
        cnt       <= CNT_LOAD;
      end else if (state == WAITING && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      ready <= enter_resp;
      err   <= enter_resp && resp_bad;
      rdata <= (enter_resp && !resp_we && !resp_bad) ? mem_rdata : '0;

      if (acc_we) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the multicycle MIPS core: the slave end of the processor's memory interface, the side that `memwrite`/`dataadr`/`writedata` drive into. It accepts one read or write request at a time and returns a single-cycle `ready` pulse after a parameterisable number of wait states. It flags misaligned or out-of-range accesses and counts committed writes. A side-band preload port lets benches load a program image before releasing the core.

## Interface
- `DEPTH` = 64: memory size in 32-bit words; word index is `addr[31:2]`.
- `WAIT` = 2: wait states per access, 0..15.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: request strobe, sampled only at accept points.
- `we` in 1: 1 = write, 0 = read; captured with `req`.
- `addr` in 32: byte address; captured with `req`.
- `wdata` in 32: write data; captured with `req`.
- `rdata` out 32: read data, valid only while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `ready`; the access was misaligned or out of range.
- `wr_count` out 16: committed-write counter, wraps modulo 2^16.
- `load_en` in 1: preload write strobe.
- `load_addr` in $clog2(DEPTH): preload word index.
- `load_data` in 32: preload data.

## Operation
- FSM states: IDLE, WAITING, RESP.
- **Accept point:** any edge where the state is IDLE, or RESP, and `req`=1. At accept, capture `we`, `addr` and `wdata`, and compute `bad = (addr[1:0]!=0) | (addr[31:2] >= DEPTH)`.
  - `WAIT`=0: next state is RESP.
  - Otherwise: load the counter with `WAIT`-1 and go to WAITING.
- **WAITING:** decrement the counter each edge. At counter==0, go to RESP. At that same edge, for a good write, write `mem[idx] <= wdata` and increment `wr_count`.
- **RESP:** `ready`=1 for exactly this cycle.
  - `rdata` = `mem[idx]` for a good read, otherwise 0.
  - `err` = `bad`.
  - At the next edge, go to IDLE, or accept a new request if `req`=1 (back-to-back).
- `req` is ignored in WAITING. Captured fields do not follow input changes after accept.
- A bad access never writes memory and never increments `wr_count`.
- **Preload:** `load_en`=1 writes `mem[load_addr] <= load_data` only when the state is IDLE and `req`=0. Otherwise it is ignored silently. There is no acknowledge.
- **Reset (async):**
  - State goes to IDLE, counter to 0.
  - `ready`=0, `err`=0, `rdata`=0, `wr_count`=0.
  - Memory contents are not cleared.
- **Reset mid-operation:** a write whose commit edge has not yet occurred is discarded; memory and `wr_count` are unchanged. A committed write survives reset.

## Timing
- Latency from the accept edge to the `ready` cycle is `WAIT`+1 cycles. Default is 3.
- The write commit edge is the edge that enters RESP. Read data reflects any write committed at or before that edge.
- Back-to-back throughput is one access per `WAIT`+1 cycles.
- `ready`, `err` and `rdata` are registered outputs. Each is asserted for one cycle only.

## Structure
- Package `mem_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, WAITING, RESP} mem_state_t`
  - the 32-bit word constant type
  - `MAX_WAIT` = 15
- Sub-module `mem_array`: `DEPTH`×32 storage with one synchronous write port (muxed between the access port and preload) and one combinational read port.
- `mem_responder` holds the FSM, the wait counter, the error check and `wr_count`.

## Test plan
All scenarios use `DEPTH`=64 and `WAIT`=2.
1. Preload word 21 = 0x0000_0005, then read `addr`=84 → `ready` 3 cycles after accept, `rdata`=5, `err`=0.
2. Write `addr`=84, `wdata`=7, then read 84 → first `ready` with `wr_count`=1, second `ready` with `rdata`=7. Neither pulse lasts more than one cycle.
3. Write `addr`=0x55 (misaligned), then read 84 → `ready` with `err`=1, `wr_count` unchanged, read returns 7.
4. Read `addr`=256 (word 64, out of range) → `ready` with `err`=1 and `rdata`=0.
5. Hold `req`=1 across two reads (80, 84) → `ready` pulses exactly 3 cycles apart with no idle bubble. `req` toggled during WAITING has no effect.
6. Assert `reset` one cycle into WAITING of a write to 80 with data 9 → `ready` never pulses, all outputs 0, and a subsequent read of 80 returns the old value.
